aes_key_expander: RTL and testbench

//  Parametrised AES key-schedule engine; successor to the byte-loaded 128-bit key memory.
//  Key bytes load over the same cs/RW/address byte bus. On start it generates all
//  4*(NR+1) schedule words (FIPS-197 KeyExpansion), one word per cycle, into an internal store.
//  The cipher datapath then reads any 128-bit round key by round index.

---
 rtl/aes_key_expander.sv | 183 ++++++++++++++++++
 tb/tb_aes_key_expander.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// AES key-schedule engine: the key is loaded over a byte bus, expanded one word per
// cycle into an internal store, and served to the cipher datapath as 128-bit round keys.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] xx;
      p  = 8'h00;
      xx = x;
      for (int k = 0; k < 8; k++) begin
         if (y[k]) p = p ^ xx;
         xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs)
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] q;
      r = 8'h01;
      q = x;
      for (int k = 1; k < 8; k++) begin
         q = gmul(q, q);
         r = gmul(r, q);
      end
      return r;
   endfunction

   logic [7:0] inv;

   always_comb begin
      inv = ginv(a);
      s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_key_expander #(
   parameter int KEY_BITS = 128
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [7:0]   DataIN,
   input  logic [4:0]   address,
   input  logic         cs,
   input  logic         RW,
   output logic [7:0]   DataOut,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         keys_ready,
   input  logic         rk_rd,
   input  logic [3:0]   rk_round,
   output logic [127:0] rk_out,
   output logic         rk_valid,
   output logic         rk_err
);

   localparam int         NK    = KEY_BITS / 32;
   localparam int         NR    = NK + 6;
   localparam int         TOTAL = 4 * (NR + 1);
   localparam logic [5:0] NK6   = 6'(NK);
   localparam logic [5:0] LAST6 = 6'(TOTAL - 1);
   localparam logic [5:0] NB6   = 6'(4 * NK);
   localparam logic [3:0] NR4   = 4'(NR);
   localparam logic [2:0] NKM1  = 3'(NK - 1);

   typedef enum logic {S_IDLE, S_EXPAND} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   state_t      state;
   logic [31:0] w [0:TOTAL-1];
   logic [5:0]  i;
   logic [2:0]  kc;
   logic [7:0]  rcon;

   logic [31:0] prev_w;
   logic [31:0] base_w;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] t_mix;
   logic [31:0] next_w;
   logic        in_range;
   logic [5:0]  wr_idx;
   logic [4:0]  lane;
   logic [5:0]  rk_idx;

   assign in_range = ({1'b0, address} < NB6);
   assign wr_idx   = {3'b000, address[4:2]};
   assign lane     = {~address[1:0], 3'b000};
   assign rk_idx   = {rk_round, 2'b00};

   // kc tracks i mod NK so no divider is needed for the 192-bit schedule
   always_comb begin
      prev_w = w[i - 6'd1];
      base_w = w[i - NK6];
      sub_in = (kc == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      if (kc == 3'd0)
         t_mix = sub_out ^ {rcon, 24'h000000};
      else if (NK == 8 && kc == 3'd4)
         t_mix = sub_out;
      else
         t_mix = prev_w;
      next_w = base_w ^ t_mix;
   end

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         i          <= 6'd0;
         kc         <= 3'd0;
         rcon       <= 8'h01;
         busy       <= 1'b0;
         done       <= 1'b0;
         keys_ready <= 1'b0;
         DataOut    <= 8'h00;
         rk_out     <= '0;
         rk_valid   <= 1'b0;
         rk_err     <= 1'b0;
         for (int k = 0; k < TOTAL; k++) w[k] <= 32'h0;
      end else begin
         done     <= 1'b0;
         rk_valid <= 1'b0;
         rk_err   <= 1'b0;

         if (rk_rd) begin
            if (!busy && rk_round <= NR4) begin
               rk_out   <= {w[rk_idx], w[rk_idx + 6'd1], w[rk_idx + 6'd2], w[rk_idx + 6'd3]};
               rk_valid <= 1'b1;
            end else begin
               rk_err <= 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (cs && !RW && in_range) begin
                  w[wr_idx][lane +: 8] <= DataIN;
                  keys_ready           <= 1'b0;
               end
               if (cs && RW)
                  DataOut <= in_range ? w[wr_idx][lane +: 8] : 8'h00;
               if (start) begin
                  state      <= S_EXPAND;
                  i          <= NK6;
                  kc         <= 3'd0;
                  rcon       <= 8'h01;
                  busy       <= 1'b1;
                  keys_ready <= 1'b0;
               end
            end
            S_EXPAND: begin
               w[i] <= next_w;
               kc   <= (kc == NKM1) ? 3'd0 : kc + 3'd1;
               if (kc == 3'd0) rcon <= xtime(rcon);
               if (i == LAST6) begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  keys_ready <= 1'b1;
               end else begin
                  i <= i + 6'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: 128/192/256-bit instances share one byte bus and start line
// and are checked against FIPS-197 vectors and a table-driven key-schedule model.

module tb_aes_key_expander;

   logic         CLK = 1'b0;
   logic         RST;
   logic [7:0]   DataIN;
   logic [4:0]   address;
   logic         cs, RW, start, rk_rd;
   logic [3:0]   rr   [3];
   logic [7:0]   dout [3];
   logic         bsy  [3];
   logic         dn   [3];
   logic         kr   [3];
   logic         rkv  [3];
   logic         rke  [3];
   logic [127:0] rko  [3];

   int n_err = 0;
   int n_chk = 0;

   logic [7:0] kb   [32];
   logic [7:0] ex_t [256];
   logic [7:0] lg_t [256];

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_key_expander #(.KEY_BITS(128 + 64 * g)) u_dut (
         .CLK(CLK), .RST(RST), .DataIN(DataIN), .address(address), .cs(cs), .RW(RW),
         .DataOut(dout[g]), .start(start), .busy(bsy[g]), .done(dn[g]),
         .keys_ready(kr[g]), .rk_rd(rk_rd), .rk_round(rr[g]), .rk_out(rko[g]),
         .rk_valid(rkv[g]), .rk_err(rke[g])
      );
   end

   function automatic int nk_of(int g);
      return 4 + 2 * g;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box from log/antilog tables (generator 3) plus the bitwise affine map
   function automatic logic [7:0] sbox_ref(input logic [7:0] b);
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] s;
      c   = 8'h63;
      inv = (b == 8'h00) ? 8'h00 : ex_t[(255 - int'(lg_t[b])) % 255];
      for (int k = 0; k < 8; k++)
         s[k] = inv[k] ^ inv[(k + 4) % 8] ^ inv[(k + 5) % 8] ^ inv[(k + 6) % 8]
              ^ inv[(k + 7) % 8] ^ c[k];
      return s;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_ref(x[31:24]), sbox_ref(x[23:16]), sbox_ref(x[15:8]), sbox_ref(x[7:0])};
   endfunction

   function automatic logic [127:0] model_rk(int nk, int r);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int j = 0; j < 60; j++) w[j] = 32'h0;
      for (int j = 0; j < nk; j++) w[j] = {kb[4*j], kb[4*j+1], kb[4*j+2], kb[4*j+3]};
      for (int j = nk; j < 4 * (nk + 7); j++) begin
         t = w[j-1];
         if (j % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && j % nk == 4) begin
            t = subw(t);
         end
         w[j] = w[j-nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic wr_byte(input int a, input logic [7:0] d);
      address = 5'(a); DataIN = d; cs = 1'b1; RW = 1'b0;
      tick();
      cs = 1'b0;
      kb[a] = d;
   endtask

   task automatic load_key(input logic [255:0] key, input int nbytes);
      for (int k = 0; k < nbytes; k++) wr_byte(k, key[255 - 8*k -: 8]);
   endtask

   task automatic rd_byte(input int a);
      address = 5'(a); cs = 1'b1; RW = 1'b1;
      tick();
      cs = 1'b0; RW = 1'b0;
   endtask

   task automatic rk_read(input int r0, input int r1, input int r2);
      rr[0] = 4'(r0); rr[1] = 4'(r1); rr[2] = 4'(r2); rk_rd = 1'b1;
      tick();
      rk_rd = 1'b0;
   endtask

   task automatic expand_run(input bit disturb);
      int lat [3];
      for (int g = 0; g < 3; g++) lat[g] = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 70; c++) begin
         if (disturb && c == 5) begin
            address = 5'd0; DataIN = 8'hff; cs = 1'b1; RW = 1'b0; start = 1'b1;
            rr[0] = 4'd0; rr[1] = 4'd0; rr[2] = 4'd0; rk_rd = 1'b1;
         end
         tick();
         if (disturb && c == 5) begin
            cs = 1'b0; start = 1'b0; rk_rd = 1'b0;
            for (int g = 0; g < 3; g++) begin
               chk($sformatf("err_busy_g%0d", g), 128'(rke[g]), 128'd1);
               chk($sformatf("noval_busy_g%0d", g), 128'(rkv[g]), 128'd0);
            end
         end
         if (c == 1)
            for (int g = 0; g < 3; g++) chk($sformatf("busy_g%0d", g), 128'(bsy[g]), 128'd1);
         for (int g = 0; g < 3; g++)
            if (dn[g] && lat[g] == 0) lat[g] = c;
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("latency_g%0d", g), 128'(lat[g]), 128'(4 * (nk_of(g) + 7) - nk_of(g)));
         chk($sformatf("ready_g%0d", g), 128'(kr[g]), 128'd1);
         chk($sformatf("idle_g%0d", g), 128'(bsy[g]), 128'd0);
      end
   endtask

   task automatic check_rounds();
      for (int r = 0; r < 15; r++) begin
         rk_read(r > 10 ? 10 : r, r > 12 ? 12 : r, r);
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("rk_g%0d_r%0d", g, r), rko[g], model_rk(nk_of(g), int'(rr[g])));
            chk($sformatf("rkv_g%0d_r%0d", g, r), 128'(rkv[g]), 128'd1);
         end
      end
   endtask

   initial begin
      logic [7:0] e;
      int         dcount;
      e = 8'h01;
      for (int k = 0; k < 256; k++) begin ex_t[k] = 8'h00; lg_t[k] = 8'h00; end
      for (int k = 0; k < 255; k++) begin
         ex_t[k] = e;
         lg_t[e] = 8'(k);
         e = e ^ xt(e);
      end
      for (int k = 0; k < 32; k++) kb[k] = 8'h00;

      RST = 1'b1; DataIN = 8'h00; address = 5'd0; cs = 1'b0; RW = 1'b0;
      start = 1'b0; rk_rd = 1'b0;
      for (int g = 0; g < 3; g++) rr[g] = 4'd0;
      repeat (3) tick();
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_busy_g%0d", g), 128'(bsy[g]), 128'd0);
         chk($sformatf("rst_done_g%0d", g), 128'(dn[g]), 128'd0);
         chk($sformatf("rst_ready_g%0d", g), 128'(kr[g]), 128'd0);
         chk($sformatf("rst_flags_g%0d", g), 128'({rkv[g], rke[g]}), 128'd0);
         chk($sformatf("rst_dout_g%0d", g), 128'(dout[g]), 128'd0);
         chk($sformatf("rst_rkout_g%0d", g), rko[g], 128'd0);
      end
      RST = 1'b0;
      tick();

      load_key(256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_00000000_00000000_00000000_00000000, 16);
      expand_run(1'b0);
      rk_read(10, 10, 10);
      chk("fips128_r10", rko[0], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      rk_read(1, 1, 1);
      chk("fips128_r1", rko[0], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      check_rounds();

      load_key(256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b_00000000_00000000, 24);
      expand_run(1'b0);
      rk_read(10, 12, 12);
      chk("fips192_r12", rko[1], 128'he98ba06f_448c773c_8ecc7204_01002202);

      load_key(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4, 32);
      expand_run(1'b0);
      rk_read(10, 12, 14);
      chk("fips256_r14", rko[2], 128'hfe4890d1_e6188d0b_046df344_706c631e);
      check_rounds();

      expand_run(1'b1);
      check_rounds();

      rk_read(11, 13, 15);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("oob_err_g%0d", g), 128'(rke[g]), 128'd1);
         chk($sformatf("oob_noval_g%0d", g), 128'(rkv[g]), 128'd0);
         chk($sformatf("oob_held_g%0d", g), rko[g], model_rk(nk_of(g), nk_of(g) + 6));
      end

      rd_byte(31);
      chk("rd31_g0", 128'(dout[0]), 128'd0);
      chk("rd31_g1", 128'(dout[1]), 128'd0);
      chk("rd31_g2", 128'(dout[2]), 128'(kb[31]));
      rd_byte(5);
      for (int g = 0; g < 3; g++) chk($sformatf("rd5_g%0d", g), 128'(dout[g]), 128'(kb[5]));

      wr_byte(2, 8'h5a);
      for (int g = 0; g < 3; g++) chk($sformatf("wr_clr_ready_g%0d", g), 128'(kr[g]), 128'd0);

      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < 32; k++) wr_byte(k, 8'($urandom));
         expand_run(1'b0);
         for (int q = 0; q < 4; q++) begin
            rk_read(int'($urandom_range(0, 10)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 14)));
            for (int g = 0; g < 3; g++)
               chk($sformatf("rand_g%0d_r%0d", g, rr[g]), rko[g], model_rk(nk_of(g), int'(rr[g])));
         end
      end

      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      #2 RST = 1'b1;
      #1;
      for (int g = 0; g < 3; g++) chk($sformatf("abort_busy_g%0d", g), 128'(bsy[g]), 128'd0);
      @(negedge CLK);
      RST = 1'b0;
      dcount = 0;
      for (int c = 0; c < 70; c++) begin
         tick();
         for (int g = 0; g < 3; g++) if (dn[g]) dcount++;
      end
      chk("abort_no_done", 128'(dcount), 128'd0);
      rk_read(0, 0, 0);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("abort_ready_g%0d", g), 128'(kr[g]), 128'd0);
         chk($sformatf("abort_rk0_g%0d", g), rko[g], 128'd0);
         chk($sformatf("abort_rkv_g%0d", g), 128'(rkv[g]), 128'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
